// File: rtl/ctrl_pipe_resolve.sv
// ctrl_pipe_resolve: carries decoded EX/MEM control bundles through the
// ID/EX, EX/MEM and MEM/WB control registers, resolves jumps and branches
// in MEM (pc_sel/flush), and detects load-use hazards (stall + bubble).
// Every output is qualified by the valid bit of the stage it belongs to,
// so a bubble or a killed slot always presents all-zero controls.
module ctrl_pipe_resolve #(
    parameter int REG_W = 6,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       ex_ctrl_in,
    input  logic [6:0]       mem_ctrl_in,
    input  logic [REG_W-1:0] id_rd,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             alu_n,
    input  logic             alu_z,
    output logic             stall_if,
    output logic [2:0]       ex_aluop,
    output logic             mem_read,
    output logic             mem_write,
    output logic [1:0]       pc_sel,
    output logic             flush,
    output logic             wb_regwrite,
    output logic             wb_memtoreg,
    output logic             wb_pctoreg,
    output logic [REG_W-1:0] wb_rd,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    // pc_sel encodings
    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_REG_JMP = 2'b01;
    localparam logic [1:0] PC_MEM_JMP = 2'b10;
    localparam logic [1:0] PC_BRANCH = 2'b11;

    // ID/EX: the full decode bundles plus destination register.
    // Source specifiers are only needed for the hazard compare, which is
    // done against the live decode fields, so they are not stored.
    logic             idex_valid;
    logic [4:0]       idex_ex;
    logic [6:0]       idex_mem;
    logic [REG_W-1:0] idex_rd;

    // EX/MEM: ALUOP is consumed in EX and is dropped here.
    logic             exmem_valid;
    logic             exmem_memread;
    logic             exmem_memwrite;
    logic             exmem_regwrite;
    logic             exmem_memtoreg;
    logic             exmem_pctoreg;
    logic             exmem_jump;
    logic             exmem_jumpmem;
    logic             exmem_branchn;
    logic             exmem_branchz;
    logic             exmem_n;
    logic             exmem_z;
    logic [REG_W-1:0] exmem_rd;

    // MEM/WB: only write-back controls survive to this stage.
    logic             memwb_valid;
    logic             memwb_regwrite;
    logic             memwb_memtoreg;
    logic             memwb_pctoreg;
    logic [REG_W-1:0] memwb_rd;

    logic [CNT_W-1:0] redirect_q;
    logic [CNT_W-1:0] bubble_q;

    logic             hz;
    logic             branch_taken;
    logic [1:0]       pc_sel_c;
    logic             flush_c;
    logic             stall_c;

    // Load-use hazard: a load in EX that writes a register the decode
    // instruction reads. A taken redirect overrides it, since the decode
    // instruction is about to be killed anyway.
    assign hz = idex_valid & idex_ex[1] & idex_mem[6] & id_valid &
                ((idex_rd == id_rs) | (idex_rd == id_rt));

    assign branch_taken = (exmem_branchn & exmem_n) | (exmem_branchz & exmem_z);

    // Redirect select for the instruction in MEM: JumpMem > Jump > branch.
    always_comb begin
        pc_sel_c = PC_SEQ;
        if (exmem_valid) begin
            if (exmem_jumpmem)
                pc_sel_c = PC_MEM_JMP;
            else if (exmem_jump)
                pc_sel_c = PC_REG_JMP;
            else if (branch_taken)
                pc_sel_c = PC_BRANCH;
        end
    end

    assign flush_c = (pc_sel_c != PC_SEQ);
    assign stall_c = hz & ~flush_c;

    // Pipeline control registers: advance every edge; a stall inserts a
    // bubble into ID/EX, a flush kills the two younger slots (ID/EX and
    // EX/MEM) while the redirecting instruction still moves into MEM/WB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_valid     <= 1'b0;
            idex_ex        <= '0;
            idex_mem       <= '0;
            idex_rd        <= '0;
            exmem_valid    <= 1'b0;
            exmem_memread  <= 1'b0;
            exmem_memwrite <= 1'b0;
            exmem_regwrite <= 1'b0;
            exmem_memtoreg <= 1'b0;
            exmem_pctoreg  <= 1'b0;
            exmem_jump     <= 1'b0;
            exmem_jumpmem  <= 1'b0;
            exmem_branchn  <= 1'b0;
            exmem_branchz  <= 1'b0;
            exmem_n        <= 1'b0;
            exmem_z        <= 1'b0;
            exmem_rd       <= '0;
            memwb_valid    <= 1'b0;
            memwb_regwrite <= 1'b0;
            memwb_memtoreg <= 1'b0;
            memwb_pctoreg  <= 1'b0;
            memwb_rd       <= '0;
        end else begin
            idex_valid     <= id_valid & ~flush_c & ~stall_c;
            idex_ex        <= ex_ctrl_in;
            idex_mem       <= mem_ctrl_in;
            idex_rd        <= id_rd;

            exmem_valid    <= idex_valid & ~flush_c;
            exmem_memread  <= idex_ex[1];
            exmem_memwrite <= idex_ex[0];
            exmem_regwrite <= idex_mem[6];
            exmem_memtoreg <= idex_mem[5];
            exmem_pctoreg  <= idex_mem[4];
            exmem_jump     <= idex_mem[3];
            exmem_jumpmem  <= idex_mem[2];
            exmem_branchn  <= idex_mem[1];
            exmem_branchz  <= idex_mem[0];
            exmem_n        <= alu_n;
            exmem_z        <= alu_z;
            exmem_rd       <= idex_rd;

            memwb_valid    <= exmem_valid;
            memwb_regwrite <= exmem_regwrite;
            memwb_memtoreg <= exmem_memtoreg;
            memwb_pctoreg  <= exmem_pctoreg;
            memwb_rd       <= exmem_rd;
        end
    end

    // Performance counters: taken redirects and inserted load-use bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_q <= '0;
            bubble_q   <= '0;
        end else begin
            if (flush_c)
                redirect_q <= redirect_q + 1'b1;
            if (stall_c)
                bubble_q <= bubble_q + 1'b1;
        end
    end

    assign stall_if     = stall_c;
    assign ex_aluop     = idex_ex[4:2] & {3{idex_valid}};
    assign mem_read     = exmem_memread & exmem_valid;
    assign mem_write    = exmem_memwrite & exmem_valid;
    assign pc_sel       = pc_sel_c;
    assign flush        = flush_c;
    assign wb_regwrite  = memwb_regwrite & memwb_valid;
    assign wb_memtoreg  = memwb_memtoreg & memwb_valid;
    assign wb_pctoreg   = memwb_pctoreg & memwb_valid;
    assign wb_rd        = memwb_rd & {REG_W{memwb_valid}};
    assign redirect_cnt = redirect_q;
    assign bubble_cnt   = bubble_q;

endmodule
